// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial add/subtract sequencer. It drives one external
//               full-adder stage, one bit pair per clock, LSB first. It
//               latches the operands on start and reports sum, carry-out and
//               signed overflow with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             stage_a,
    output logic             stage_b,
    output logic             stage_cin,
    input  logic             stage_s,
    input  logic             stage_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_run;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_nxt;

    assign w_run     = (r_state == c_S_RUN);
    // start is honoured in IDLE and DONE only; a start during RUN is dropped.
    assign w_accept  = start && !w_run;
    assign w_last    = w_run && (r_cnt == c_CNT_LAST);
    assign w_sum_nxt = {stage_s, r_sum_sh[WIDTH-1:1]};

    // Stage drive is forced low outside RUN so the shared cell sees quiet inputs.
    assign stage_a   = w_run & r_a_sh[0];
    assign stage_b   = w_run & r_b_sh[0];
    assign stage_cin = w_run & r_carry;

    assign busy = w_run;
    assign done = (r_state == c_S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (start) w_state_nxt = c_S_RUN;
            c_S_RUN:  if (r_cnt == c_CNT_LAST) w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = start ? c_S_RUN : c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Operand capture, per-bit shifting and result latch on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            // Subtract is a + ~b + 1: invert B here and seed the carry with 1.
            r_a_sh  <= a;
            r_b_sh  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_sum_sh <= w_sum_nxt;
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_carry  <= stage_cout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                // r_carry still holds the carry into the MSB on this edge.
                r_sum  <= w_sum_nxt;
                r_cout <= stage_cout;
                r_ovf  <= r_carry ^ stage_cout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH=8) with the
//               shared stage modelled as a plain full adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             stage_a;
    logic             stage_b;
    logic             stage_cin;
    logic             stage_s;
    logic             stage_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_assert = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sub        (sub),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .stage_a    (stage_a),
        .stage_b    (stage_b),
        .stage_cin  (stage_cin),
        .stage_s    (stage_s),
        .stage_cout (stage_cout),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .cout       (cout),
        .ovf        (ovf)
    );

    // Shared full-adder cell.
    assign stage_s    = stage_a ^ stage_b ^ stage_cin;
    assign stage_cout = (stage_a & stage_b) | (stage_a & stage_cin) | (stage_b & stage_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and wait for done; reports edges from the accepting
    // edge (counted as 1) to the edge after which done is seen, and RUN cycles.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                         input logic tsub, output int edges, output int busy_cyc);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk);
        edges    = 1;
        busy_cyc = 0;
        #1 start = 1'b0;
        while (!done && edges < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            edges++;
            #1;
        end
        n_assert++;
        if (!done) begin
            n_fail++;
            $display("FAIL op_timeout: done=%0b required 1 after %0d edges", done, edges);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        n_assert++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%0b done=%0b sum=%h cout=%0b ovf=%0b required all 0",
                     busy, done, sum, cout, ovf);
        end
        n_assert++;
        if ({stage_a, stage_b, stage_cin} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_stage: stage=%b required 000", {stage_a, stage_b, stage_cin});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_assert++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%0b done=%0b required 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        int e, bc;
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, e, bc);
        n_assert++;
        if (e !== 9 || bc !== 8) begin
            n_fail++;
            $display("FAIL add_latency: edges=%0d busy=%0d required 9 8", e, bc);
        end
        n_assert++;
        if ({sum, cout, ovf} !== {8'h96, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_5a_3c: sum=%h cout=%0b ovf=%0b required 96 0 1", sum, cout, ovf);
        end
        // DONE without start returns to IDLE after one cycle.
        @(posedge clk); #1;
        n_assert++;
        if ({busy, done, sum} !== {2'b00, 8'h96}) begin
            n_fail++;
            $display("FAIL done_pulse: busy=%0b done=%0b sum=%h required 0 0 96", busy, done, sum);
        end
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, e, bc);
        n_assert++;
        if ({sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ff_01: sum=%h cout=%0b ovf=%0b required 00 1 0", sum, cout, ovf);
        end
        do_op(8'h7F, 8'h00, 1'b1, 1'b0, e, bc);
        n_assert++;
        if ({sum, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_7f_cin: sum=%h cout=%0b ovf=%0b required 80 0 1", sum, cout, ovf);
        end
    endtask

    task automatic test_sub();
        int e, bc;
        do_op(8'h10, 8'h20, 1'b0, 1'b1, e, bc);
        n_assert++;
        if ({sum, cout, ovf} !== {8'hF0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_10_20: sum=%h cout=%0b ovf=%0b required f0 0 0", sum, cout, ovf);
        end
        do_op(8'h80, 8'h01, 1'b1, 1'b1, e, bc);
        n_assert++;
        if ({sum, cout, ovf} !== {8'h7F, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_80_01: sum=%h cout=%0b ovf=%0b required 7f 1 1", sum, cout, ovf);
        end
    endtask

    task automatic test_start_ignored();
        int edges;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        edges = 1;
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        edges += 3;
        #1 a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        edges++;
        #1 start = 1'b0;
        while (!done && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
        end
        n_assert++;
        if (edges !== 9) begin
            n_fail++;
            $display("FAIL ignore_latency: edges=%0d required 9", edges);
        end
        n_assert++;
        if ({sum, cout, ovf} !== {8'h46, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_result: sum=%h cout=%0b ovf=%0b required 46 0 0", sum, cout, ovf);
        end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        do_op(8'h01, 8'h02, 1'b0, 1'b0, e, bc);
        // Called straight from the DONE cycle: start lands on the DONE edge.
        do_op(8'hC8, 8'h64, 1'b0, 1'b1, e, bc);
        n_assert++;
        if (e !== 9 || bc !== 8) begin
            n_fail++;
            $display("FAIL b2b_latency: edges=%0d busy=%0d required 9 8", e, bc);
        end
        n_assert++;
        if ({sum, cout, ovf} !== {8'h64, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_result: sum=%h cout=%0b ovf=%0b required 64 1 1", sum, cout, ovf);
        end
    endtask

    task automatic test_async_reset();
        int e, bc;
        int seen_done;
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #0.5;
        n_assert++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%0b done=%0b sum=%h cout=%0b ovf=%0b required all 0",
                     busy, done, sum, cout, ovf);
        end
        #0.5 rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        n_assert++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: active_cycles=%0d required 0", seen_done);
        end
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, e, bc);
        n_assert++;
        if ({sum, cout, ovf} !== {8'h96, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL after_reset_op: sum=%h cout=%0b ovf=%0b required 96 0 1", sum, cout, ovf);
        end
    endtask

    task automatic test_random();
        int e, bc;
        logic [7:0] ra, rb, bb, es;
        logic       rc, rs, ec, eo;
        logic [8:0] full;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            bb   = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, bb} + {8'd0, (rs ? 1'b1 : rc)};
            es   = full[7:0];
            ec   = full[8];
            eo   = (ra[7] == bb[7]) && (es[7] != ra[7]);
            do_op(ra, rb, rc, rs, e, bc);
            n_assert++;
            if ({sum, cout, ovf} !== {es, ec, eo}) begin
                n_fail++;
                $display("FAIL rand_%0d: a=%h b=%h cin=%0b sub=%0b got sum=%h cout=%0b ovf=%0b required %h %0b %0b",
                         i, ra, rb, rc, rs, sum, cout, ovf, es, ec, eo);
            end
            n_assert++;
            if ({stage_a, stage_b, stage_cin} !== 3'b000) begin
                n_fail++;
                $display("FAIL rand_stage_idle_%0d: stage=%b required 000", i, {stage_a, stage_b, stage_cin});
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
